// File: rtl/vga_write_arbiter.sv
// rtl/vga_write_arbiter.sv - arbitrates pixel-writer channels onto one registered VGA write port
// Saturating beat/stall counters are built only when VGA_WRITE_ARBITER_STATS_EN is defined.
module vga_write_arbiter #(
  parameter int NUM_CH    = 2,
  parameter int X_W       = 10,
  parameter int Y_W       = 9,
  parameter int COLOR_W   = 9,
  parameter int RR_MODE   = 0,
  parameter int MAX_BURST = 64,
  localparam int GID_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH-1:0]          req_last,
  input  logic [NUM_CH*X_W-1:0]      req_x,
  input  logic [NUM_CH*Y_W-1:0]      req_y,
  input  logic [NUM_CH*COLOR_W-1:0]  req_color,
  output logic [NUM_CH-1:0]          req_ready,
  output logic [X_W-1:0]             out_x,
  output logic [Y_W-1:0]             out_y,
  output logic [COLOR_W-1:0]         out_color,
  output logic                       out_write,
  input  logic                       out_ready,
  output logic [GID_W-1:0]           grant_id,
  output logic                       grant_valid
`ifdef VGA_WRITE_ARBITER_STATS_EN
  ,
  input  logic                       stat_clear,
  output logic [31:0]                stat_beats,
  output logic [31:0]                stat_stall
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t             r_state, w_state_nxt;
  logic [GID_W-1:0]   r_grant_id, r_last_grant;
  logic [GID_W-1:0]   w_winner, w_low, w_high;
  logic               w_high_found;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic               w_sel_valid, w_sel_last;
  logic [X_W-1:0]     w_sel_x, r_out_x;
  logic [Y_W-1:0]     w_sel_y, r_out_y;
  logic [COLOR_W-1:0] w_sel_color, r_out_color;
  logic               r_out_write, w_owner_ready, w_beat, w_release;

  // w_low is the lowest valid index; w_high is the lowest valid index above the last owner.
  always_comb begin
    w_low        = '0;
    w_high       = '0;
    w_high_found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        w_low = GID_W'(i);
        if (GID_W'(i) > r_last_grant) begin
          w_high       = GID_W'(i);
          w_high_found = 1'b1;
        end
      end
    end
    w_winner = (RR_MODE != 0 && w_high_found) ? w_high : w_low;
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_x     = '0;
    w_sel_y     = '0;
    w_sel_color = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (GID_W'(i) == r_grant_id) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_x     = req_x[i*X_W +: X_W];
        w_sel_y     = req_y[i*Y_W +: Y_W];
        w_sel_color = req_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  assign w_owner_ready = out_ready | ~r_out_write;
  assign w_beat        = (r_state == S_GRANT) & w_sel_valid & w_owner_ready;
  assign w_release     = w_beat & (w_sel_last | (r_burst_cnt == CNT_W'(MAX_BURST - 1)));

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) w_state_nxt = S_GRANT;
      end
      S_GRANT: begin
        for (int i = 0; i < NUM_CH; i++) begin
          req_ready[i] = (GID_W'(i) == r_grant_id) & w_owner_ready;
        end
        if (w_release) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GID_W'(NUM_CH - 1);
      r_burst_cnt  <= '0;
      r_out_write  <= 1'b0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_out_color  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && |req_valid) begin
        r_grant_id  <= w_winner;
        r_burst_cnt <= '0;
      end
      if (w_beat) r_burst_cnt <= r_burst_cnt + 1'b1;
      if (w_release) r_last_grant <= r_grant_id;
      if (w_beat) begin
        r_out_write <= 1'b1;
        r_out_x     <= w_sel_x;
        r_out_y     <= w_sel_y;
        r_out_color <= w_sel_color;
      end else if (out_ready) begin
        r_out_write <= 1'b0;
      end
    end
  end

  assign out_x       = r_out_x;
  assign out_y       = r_out_y;
  assign out_color   = r_out_color;
  assign out_write   = r_out_write;
  assign grant_id    = r_grant_id;
  assign grant_valid = (r_state == S_GRANT);

`ifdef VGA_WRITE_ARBITER_STATS_EN
  logic [31:0] r_stat_beats, r_stat_stall;

  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      r_stat_beats <= '0;
      r_stat_stall <= '0;
    end else begin
      if (r_out_write && out_ready && r_stat_beats != '1) r_stat_beats <= r_stat_beats + 1'b1;
      if (r_out_write && !out_ready && r_stat_stall != '1) r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign stat_beats = r_stat_beats;
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: doc/vga_write_arbiter.md
VGA_WRITE_ARBITER -- requirements
Module: vga_write_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of pixel-writer channels (2..8).
REQ-002 SHALL have parameter X_W, default 10, pixel x width.
REQ-003 SHALL have parameter Y_W, default 9, pixel y width.
REQ-004 SHALL have parameter COLOR_W, default 9, colour width.
REQ-005 SHALL have parameter RR_MODE, default 0: 0 = fixed priority, lowest index wins; 1 = round-robin.
REQ-006 SHALL have parameter MAX_BURST, default 64, maximum beats per grant (power of two, 2..1024).
REQ-007 SHALL have port clk, input, 1, clock; all logic is on the rising edge.
REQ-008 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-009 SHALL have port req_valid, input, NUM_CH, per-channel pixel valid.
REQ-010 SHALL have port req_last, input, NUM_CH, per-channel final pixel of a sprite.
REQ-011 SHALL have port req_x, input, NUM_CH*X_W, packed x; channel i occupies bits [i*X_W +: X_W].
REQ-012 SHALL have port req_y, input, NUM_CH*Y_W, packed y, same packing as req_x.
REQ-013 SHALL have port req_color, input, NUM_CH*COLOR_W, packed colour, same packing as req_x.
REQ-014 SHALL have port req_ready, output, NUM_CH, per-channel accept.
REQ-015 SHALL have ports out_x, out_y, out_color, output, X_W / Y_W / COLOR_W, registered pixel to the VGA adapter.
REQ-016 SHALL have port out_write, output, 1, out_* valid.
REQ-017 SHALL have port out_ready, input, 1, sink accept; tie to 1 for the VGA adapter.
REQ-018 SHALL have port grant_id, output, clog2(NUM_CH), current owner; grant_valid, output, 1, owner held.

Function
REQ-019 SHALL implement FSM states IDLE and GRANT.
REQ-020 SHALL, in IDLE with any req_valid high, select a winner, register grant_id and go to GRANT next cycle; req_ready SHALL be all-zero in IDLE.
REQ-021 SHALL, in fixed mode, select the lowest-index valid channel.
REQ-022 SHALL, in round-robin mode, select the first valid channel after last_grant, ascending with wrap from NUM_CH-1 to 0.
REQ-023 SHALL, in GRANT, drive req_ready[grant_id] = out_ready OR NOT out_write, with all other req_ready bits 0.
REQ-024 SHALL define a beat as req_valid[g] AND req_ready[g]; the beat SHALL appear on out_* with out_write=1 exactly one cycle later.
REQ-025 SHALL hold out_* stable while out_write=1 and out_ready=0, and SHALL clear out_write after an accepted output when no new beat is taken.
REQ-026 SHALL keep a burst counter, cleared on grant, incremented per beat.
REQ-027 SHALL release the grant (GRANT to IDLE, last_grant <= g) on a beat with req_last[g]=1 or on the MAX_BURST-th beat, whichever comes first.
REQ-028 SHALL keep the grant while the owner deasserts req_valid mid-sprite; no timeout.
REQ-029 SHALL insert exactly one IDLE cycle between consecutive grants, including a re-grant of the same channel.
REQ-030 SHALL ignore req_last when req_valid is low.

Reset
REQ-031 SHALL, on reset, set the state to IDLE, out_write=0, out_x=out_y=out_color=0, grant_id=0, grant_valid=0, burst counter 0, last_grant=NUM_CH-1 so channel 0 is first in round-robin.
REQ-032 SHALL drop a burst in progress on reset mid-burst; no beat accepted in the reset cycle SHALL reach out_*.

Configuration
REQ-033 SHALL, when macro VGA_WRITE_ARBITER_STATS_EN is defined, add input stat_clear and outputs stat_beats (32-bit, total output beats accepted by the sink) and stat_stall (32-bit, cycles with out_write=1 and out_ready=0); both counters SHALL saturate, and SHALL be cleared by reset or by stat_clear.
REQ-034 SHALL, without VGA_WRITE_ARBITER_STATS_EN, omit those ports and counters entirely.

Verification
REQ-035 SHALL cover: NUM_CH=2, fixed mode, both channels valid at once with 3-pixel sprites -> ch0's 3 pixels, one gap cycle, then ch1's 3 pixels, with first out_write 2 cycles after valid.
REQ-036 SHALL cover: NUM_CH=4, RR_MODE=1, all channels continuously valid with 1-pixel sprites -> grant order 0,1,2,3,0.
REQ-037 SHALL cover: MAX_BURST=4, ch0 sends a 10-pixel sprite while ch1 is valid, round-robin -> ch0 x4, ch1, ch0 x4, ch1, ch0 x2.
REQ-038 SHALL cover: out_ready low for 5 cycles mid-burst with pixel (100,200,0x1FF) on out_* -> out_* held, req_ready=0, no beat lost or duplicated.
REQ-039 SHALL cover: reset asserted on the 2nd beat of a 4-beat burst -> next cycle out_write=0, grant_valid=0, req_ready=0; after release, ch0 is granted first.
